// File: rtl/data_memory_arbiter_pkg.sv
// data_memory_pkg: shared types and constants for the data memory arbiter.
//   arb_state_t : transaction FSM states (IDLE, ACCESS, RESP)
//   WORD_BYTES  : bytes per memory word
//   ADDR_LSB    : byte-address bits dropped to form a word index
//   req_id_t    : requester identifier (0 = core LSU, 1 = debug/DMA)
package data_memory_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ADDR_LSB   = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/data_memory_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter.
//   clk, rst_n : clock, synchronous active-low reset (pointer -> requester 0)
//   req[1:0]   : request lines
//   advance    : move the pointer past the current grant
//   grant[1:0] : one-hot grant, or zero when nothing is requested
module rr_arbiter2
  import data_memory_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  req_id_t ptr_q;
  req_id_t ptr_d;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (ptr_q == 1'b1) ? 2'b10 : 2'b01;
    end
    ptr_d = ptr_q;
    if (advance && (grant != 2'b00)) begin
      // Favour the requester that was not just served.
      ptr_d = grant[0] ? 1'b1 : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: two-requester front end for a single-port synchronous
// data memory. One transaction in flight; request-to-response latency 2.
//   clk, rst_n                 : clock, synchronous active-low reset
//   rX_valid/ready             : request handshake (ready combinational in IDLE)
//   rX_write/addr/wdata        : store flag, byte address, store data
//   rX_rvalid/rdata/err        : one-cycle response pulse with data / reject flag
//   mem_addr/write_enable/
//   mem_write_data             : word index, write strobe, write data to memory
//   mem_read_data              : registered memory read output (1-cycle latency)
module data_memory_arbiter
  import data_memory_pkg::*;
#(
  parameter int N    = 32,
  parameter int SIZE = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         r0_valid,
  output logic         r0_ready,
  input  logic         r0_write,
  input  logic [N-1:0] r0_addr,
  input  logic [N-1:0] r0_wdata,
  output logic         r0_rvalid,
  output logic [N-1:0] r0_rdata,
  output logic         r0_err,
  input  logic         r1_valid,
  output logic         r1_ready,
  input  logic         r1_write,
  input  logic [N-1:0] r1_addr,
  input  logic [N-1:0] r1_wdata,
  output logic         r1_rvalid,
  output logic [N-1:0] r1_rdata,
  output logic         r1_err,
  output logic [N-1:0] mem_addr,
  output logic         mem_write_enable,
  output logic [N-1:0] mem_write_data,
  input  logic [N-1:0] mem_read_data
);

  arb_state_t   state_q, state_d;
  req_id_t      id_q, id_d;
  logic         wr_q, wr_d;
  logic         err_q, err_d;
  logic [N-1:0] maddr_q, maddr_d;
  logic [N-1:0] mwdata_q, mwdata_d;
  logic [N-1:0] r0_rdata_q, r0_rdata_d;
  logic [N-1:0] r1_rdata_q, r1_rdata_d;
  logic         r0_err_q, r0_err_d;
  logic         r1_err_q, r1_err_d;

  logic         can_grant;
  logic [1:0]   req;
  logic [1:0]   grant;
  logic         accept;
  logic         acc_ok;
  logic         acc_err;
  req_id_t      sel_id;
  logic         sel_write;
  logic [N-1:0] sel_addr;
  logic [N-1:0] sel_wdata;
  logic [N-1:0] sel_idx;

  // Requests are only visible to the arbiter when a grant may be issued.
  always_comb begin
    can_grant = rst_n && (state_q == IDLE);
    req       = {r1_valid, r0_valid} & {2{can_grant}};
  end

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (accept),
    .grant   (grant)
  );

  always_comb begin
    accept    = (grant != 2'b00);
    sel_id    = grant[1];
    sel_write = sel_id ? r1_write : r0_write;
    sel_addr  = sel_id ? r1_addr  : r0_addr;
    sel_wdata = sel_id ? r1_wdata : r0_wdata;
    sel_idx   = sel_addr >> ADDR_LSB;
    acc_err   = (sel_addr[ADDR_LSB-1:0] != '0) || (sel_idx >= N'(SIZE));
    acc_ok    = accept && !acc_err;

    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    id_d     = accept ? sel_id : id_q;
    wr_d     = accept ? sel_write : wr_q;
    err_d    = accept ? acc_err : err_q;
    maddr_d  = acc_ok ? sel_idx : maddr_q;
    mwdata_d = acc_ok ? sel_wdata : mwdata_q;

    // Memory read data is valid during ACCESS; latch it into the granted
    // requester's response register so the other side stays untouched.
    r0_rdata_d = r0_rdata_q;
    r1_rdata_d = r1_rdata_q;
    r0_err_d   = r0_err_q;
    r1_err_d   = r1_err_q;
    if (state_q == ACCESS) begin
      if (id_q == 1'b0) begin
        r0_rdata_d = (!wr_q && !err_q) ? mem_read_data : '0;
        r0_err_d   = err_q;
      end else begin
        r1_rdata_d = (!wr_q && !err_q) ? mem_read_data : '0;
        r1_err_d   = err_q;
      end
    end

    r0_ready         = grant[0];
    r1_ready         = grant[1];
    r0_rvalid        = rst_n && (state_q == RESP) && (id_q == 1'b0);
    r1_rvalid        = rst_n && (state_q == RESP) && (id_q == 1'b1);
    r0_rdata         = r0_rdata_q;
    r1_rdata         = r1_rdata_q;
    r0_err           = r0_err_q;
    r1_err           = r1_err_q;
    // Index and data reach the memory in the accept cycle itself.
    mem_addr         = maddr_d;
    mem_write_data   = mwdata_d;
    mem_write_enable = acc_ok && sel_write;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      id_q       <= 1'b0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      maddr_q    <= '0;
      mwdata_q   <= '0;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
      r0_err_q   <= 1'b0;
      r1_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      wr_q       <= wr_d;
      err_q      <= err_d;
      maddr_q    <= maddr_d;
      mwdata_q   <= mwdata_d;
      r0_rdata_q <= r0_rdata_d;
      r1_rdata_q <= r1_rdata_d;
      r0_err_q   <= r0_err_d;
      r1_err_q   <= r1_err_d;
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Testbench for data_memory_arbiter: vector table, hand sequences for
// arbitration/reset/throughput, and randomized traffic against a model.
module tb_data_memory_arbiter;

  localparam int N    = 32;
  localparam int SIZE = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_valid, r0_ready, r0_write, r0_rvalid, r0_err;
  logic        r1_valid, r1_ready, r1_write, r1_rvalid, r1_err;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_write_enable;

  always #5 clk = ~clk;

  data_memory_arbiter #(.N(N), .SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_write(r0_write),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid),
    .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_write(r1_write),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid),
    .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_addr(mem_addr), .mem_write_enable(mem_write_enable),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // Single-port synchronous memory; read port not updated in write cycles.
  logic [31:0] mem [64] = '{default: '0};
  logic [31:0] mem_rd = '0;
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_addr[5:0]] <= mem_write_data;
    else                  mem_rd <= mem[mem_addr[5:0]];
  end
  assign mem_read_data = mem_rd;

  int total = 0;
  int bad = 0;
  logic [31:0] ref_mem [64];

  typedef struct {
    int          id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl [10];

  int acc_at [16];
  int acc_id [4];
  int acc_c [4];
  int rc [3];
  int n_acc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd);
    if (id == 0) begin
      r0_valid = v; r0_write = wr; r0_addr = a; r0_wdata = wd;
    end else begin
      r1_valid = v; r1_write = wr; r1_addr = a; r1_wdata = wd;
    end
  endtask

  task automatic idle_inputs();
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One request on one port; checks accept-cycle strobes and the T+2 response.
  task automatic do_req(input int id, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic e_err,
                        input logic [31:0] e_rd, input string nm);
    logic got;
    logic [31:0] aa;
    got = 1'b0;
    aa = a;
    set_req(id, 1'b1, wr, a, wd);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if ((id == 0) ? r0_ready : r1_ready) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk({nm, "/accept"}, 32'(got), 32'd1);
    if (!got) begin
      tick();
      idle_inputs();
      return;
    end
    chk({nm, "/we_T"}, 32'(mem_write_enable), 32'(wr && !e_err));
    if (!e_err) begin
      chk({nm, "/mem_addr"}, mem_addr, a >> 2);
      if (wr) chk({nm, "/mem_wdata"}, mem_write_data, wd);
    end
    tick();
    set_req(id, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk({nm, "/rvalid_T1"}, 32'((id == 0) ? r0_rvalid : r1_rvalid), 32'd0);
    chk({nm, "/we_T1"}, 32'(mem_write_enable), 32'd0);
    tick();
    @(negedge clk);
    chk({nm, "/rvalid_T2"}, 32'((id == 0) ? r0_rvalid : r1_rvalid), 32'd1);
    chk({nm, "/other_rvalid"}, 32'((id == 0) ? r1_rvalid : r0_rvalid), 32'd0);
    chk({nm, "/err"}, 32'((id == 0) ? r0_err : r1_err), 32'(e_err));
    chk({nm, "/rdata"}, (id == 0) ? r0_rdata : r1_rdata, e_rd);
    chk({nm, "/we_T2"}, 32'(mem_write_enable), 32'd0);
    if (wr && !e_err) ref_mem[aa[7:2]] = wd;
    tick();
  endtask

  // Randomized traffic model state
  logic        pend [2];
  logic        p_wr [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wd [2];

  function automatic logic [31:0] rnd_addr();
    int unsigned s;
    logic [31:0] a;
    s = $urandom_range(0, 9);
    if (s == 0)      a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
    else if (s == 1) a = ($urandom() | 32'h100) & 32'hFFFF_FFFC;
    else             a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
    return a;
  endfunction

  initial begin
    logic seen;
    logic r0bad;
    int k;
    int busy;
    int ptr;
    int rsp_cyc;
    int rsp_id;
    logic rsp_err;
    logic [31:0] rsp_rd;
    logic e0, e1;
    int g;
    logic a_err;
    logic [31:0] a_cur;

    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    idle_inputs();

    // Reset state
    rst_n = 1'b0;
    tick();
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    tick();
    @(negedge clk);
    chk("rst/r0_ready", 32'(r0_ready), 0);
    chk("rst/r1_ready", 32'(r1_ready), 0);
    chk("rst/r0_rvalid", 32'(r0_rvalid), 0);
    chk("rst/r1_rvalid", 32'(r1_rvalid), 0);
    chk("rst/r0_err", 32'(r0_err), 0);
    chk("rst/r1_err", 32'(r1_err), 0);
    chk("rst/r0_rdata", r0_rdata, 0);
    chk("rst/r1_rdata", r1_rdata, 0);
    chk("rst/mem_we", 32'(mem_write_enable), 0);
    chk("rst/mem_addr", mem_addr, 0);
    chk("rst/mem_wdata", mem_write_data, 0);
    tick();
    idle_inputs();
    rst_n = 1'b1;

    // Single-port vectors: write/read, misaligned, range boundaries
    tbl[0] = '{0, 1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1] = '{0, 1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2] = '{1, 1'b1, 32'h11,       32'h55555555, 1'b1, 32'h0};
    tbl[3] = '{1, 1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
    tbl[4] = '{0, 1'b1, 32'hFC,       32'h12345678, 1'b0, 32'h0};
    tbl[5] = '{0, 1'b0, 32'hFC,       32'h0,        1'b0, 32'h12345678};
    tbl[6] = '{0, 1'b0, 32'h100,      32'h0,        1'b1, 32'h0};
    tbl[7] = '{0, 1'b0, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h0};
    tbl[8] = '{1, 1'b1, 32'h102,      32'hCAFEF00D, 1'b1, 32'h0};
    tbl[9] = '{0, 1'b0, 32'h2,        32'h0,        1'b1, 32'h0};
    for (int i = 0; i < 10; i++)
      do_req(tbl[i].id, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].err, tbl[i].rd,
             $sformatf("vec%0d", i));

    // Both valid continuously: alternating grants every 3 cycles
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h10, '0);
    set_req(1, 1'b1, 1'b0, 32'hFC, '0);
    for (int i = 0; i < 16; i++) acc_at[i] = -1;
    n_acc = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if ((r0_ready || r1_ready) && n_acc < 4) begin
        acc_id[n_acc] = r1_ready ? 1 : 0;
        acc_c[n_acc] = c;
        acc_at[c] = acc_id[n_acc];
        n_acc++;
      end
      chk("rr/r0_rvalid", 32'(r0_rvalid), 32'(c >= 2 && acc_at[(c >= 2) ? c - 2 : 0] == 0));
      chk("rr/r1_rvalid", 32'(r1_rvalid), 32'(c >= 2 && acc_at[(c >= 2) ? c - 2 : 0] == 1));
      if (r0_rvalid) chk("rr/r0_rdata", r0_rdata, 32'hDEADBEEF);
      if (r1_rvalid) chk("rr/r1_rdata", r1_rdata, 32'h12345678);
      tick();
      if (n_acc == 4) idle_inputs();
    end
    chk("rr/count", n_acc, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr/id%0d", i), acc_id[i], i % 2);
      chk($sformatf("rr/cyc%0d", i), acc_c[i], 3 * i);
    end

    // Reset during ACCESS drops the response; pointer back to requester 0
    do_reset();
    set_req(1, 1'b1, 1'b0, 32'h10, '0);
    @(negedge clk);
    chk("rst_mid/r1_ready", 32'(r1_ready), 1);
    tick();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      seen = seen | r1_rvalid;
      tick();
    end
    chk("rst_mid/no_rvalid", 32'(seen), 0);
    set_req(0, 1'b1, 1'b0, 32'h10, '0);
    set_req(1, 1'b1, 1'b0, 32'h10, '0);
    @(negedge clk);
    chk("rst_mid/r0_first", 32'(r0_ready), 1);
    chk("rst_mid/r1_wait", 32'(r1_ready), 0);
    tick();
    idle_inputs();
    tick();
    tick();

    // r1 back-to-back writes: ready every 3rd cycle, r0 side quiet
    do_reset();
    k = 0;
    r0bad = 1'b0;
    set_req(1, 1'b1, 1'b1, 32'h0, 32'hA0A0_0000);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (r0_rvalid || r0_err || r0_rdata != 0 || r0_ready) r0bad = 1'b1;
      if (r1_ready && k < 3) begin
        rc[k] = c;
        ref_mem[k] = 32'hA0A0_0000 + 32'(k);
        k++;
      end
      tick();
      if (k < 3) set_req(1, 1'b1, 1'b1, 32'(4 * k), 32'hA0A0_0000 + 32'(k));
      else idle_inputs();
    end
    chk("b2b/count", k, 3);
    chk("b2b/first", rc[0], 0);
    chk("b2b/gap1", rc[1] - rc[0], 3);
    chk("b2b/gap2", rc[2] - rc[1], 3);
    chk("b2b/r0_quiet", 32'(r0bad), 0);
    for (int i = 0; i < 3; i++)
      do_req(1, 1'b0, 32'(4 * i), '0, 1'b0, 32'hA0A0_0000 + 32'(i), $sformatf("b2b_rd%0d", i));

    // Randomized traffic against the transaction-level model
    do_reset();
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    busy = 0;
    ptr = 0;
    rsp_cyc = -10;
    rsp_id = 0;
    rsp_err = 1'b0;
    rsp_rd = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          p_wr[i] = 1'($urandom_range(0, 1));
          p_addr[i] = rnd_addr();
          p_wd[i] = $urandom();
        end
        set_req(i, pend[i], pend[i] ? p_wr[i] : 1'b0, pend[i] ? p_addr[i] : '0,
                pend[i] ? p_wd[i] : '0);
      end
      @(negedge clk);
      e0 = 1'b0;
      e1 = 1'b0;
      if (busy == 0) begin
        if (pend[0] && pend[1]) begin
          e0 = (ptr == 0);
          e1 = (ptr == 1);
        end else begin
          e0 = pend[0];
          e1 = pend[1];
        end
      end
      chk("rnd/r0_ready", 32'(r0_ready), 32'(e0));
      chk("rnd/r1_ready", 32'(r1_ready), 32'(e1));
      chk("rnd/r0_rvalid", 32'(r0_rvalid), 32'(rsp_cyc == cyc && rsp_id == 0));
      chk("rnd/r1_rvalid", 32'(r1_rvalid), 32'(rsp_cyc == cyc && rsp_id == 1));
      if (rsp_cyc == cyc) begin
        chk("rnd/err", 32'((rsp_id == 0) ? r0_err : r1_err), 32'(rsp_err));
        chk("rnd/rdata", (rsp_id == 0) ? r0_rdata : r1_rdata, rsp_rd);
      end
      if (e0 || e1) begin
        g = e1 ? 1 : 0;
        a_cur = p_addr[g];
        a_err = (a_cur % 4 != 0) || ((a_cur / 4) >= SIZE);
        chk("rnd/we", 32'(mem_write_enable), 32'(p_wr[g] && !a_err));
        if (!a_err) chk("rnd/mem_addr", mem_addr, a_cur / 4);
        rsp_rd = (!p_wr[g] && !a_err) ? ref_mem[a_cur / 4] : '0;
        if (p_wr[g] && !a_err) ref_mem[a_cur / 4] = p_wd[g];
        rsp_err = a_err;
        rsp_id = g;
        rsp_cyc = cyc + 2;
        ptr = 1 - g;
        busy = 2;
        pend[g] = 1'b0;
      end else begin
        chk("rnd/we_idle", 32'(mem_write_enable), 0);
        if (busy > 0) busy--;
      end
      tick();
    end
    idle_inputs();
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
